// File: rtl/pc_fetch_if.sv
// Handshake and bus bundle between the PC/fetch unit and its surroundings.
// The "master" modport is the fetch unit's view.
interface pc_fetch_if;
   logic        pc_wr;
   logic [29:0] nPC;
   logic [29:0] curPC;
   logic        fetch_start;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic        busy;
   logic        fetch_err;

   modport master (
      input  pc_wr, nPC, fetch_start, imem_ack, imem_rdata,
      output curPC, imem_req, imem_addr, ir, ir_valid, busy, fetch_err
   );

   modport slave (
      output pc_wr, nPC, fetch_start, imem_ack, imem_rdata,
      input  curPC, imem_req, imem_addr, ir, ir_valid, busy, fetch_err
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter plus IDLE/REQ/DONE instruction-fetch sequencer feeding the instruction register.
// Optional request timeout is built only when FETCH_TIMEOUT_EN is defined.
module pc_fetch_unit #(
   parameter logic [29:0] RESET_PC       = 30'h0000_0C00,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   pc_fetch_if.master bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   if (TIMEOUT_CYCLES < 32'd1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] ir_q, ir_d;
   logic        req_q, req_d;
   logic        irv_q, irv_d;
   logic        busy_q, busy_d;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= 32'h0000_0000;
         ir_q    <= 32'h0000_0000;
         req_q   <= 1'b0;
         irv_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         req_q   <= req_d;
         irv_q   <= irv_d;
         busy_q  <= busy_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // Next-state and register updates; the PC commit is independent of the fetch FSM
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      req_d   = req_q;
      irv_d   = 1'b0;
      busy_d  = busy_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif

      if (bus.pc_wr) begin
         pc_d = bus.nPC;
      end else begin
         pc_d = pc_q;
      end

      case (state_q)
         ST_IDLE: begin
            // pc_q is the pre-edge PC, so a same-edge pc_wr does not affect this fetch
            if (bus.fetch_start) begin
               addr_d  = {pc_q, 2'b00};
               req_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               irv_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else begin
`ifdef FETCH_TIMEOUT_EN
               if (cnt_q == CNT_LAST) begin
                  req_d   = 1'b0;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
`else
               state_d = ST_REQ;
`endif
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.curPC     = pc_q;
   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.ir        = ir_q;
   assign bus.ir_valid  = irv_q;
   assign bus.busy      = busy_q;
`ifdef FETCH_TIMEOUT_EN
   assign bus.fetch_err = err_q;
`else
   assign bus.fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized fetches
// checked against a transaction-level model of PC and instruction register.
module tb_pc_fetch_unit;
   localparam logic [29:0] RESET_PC = 30'h0000_0C00;
   localparam int          TO       = 4;
`ifdef FETCH_TIMEOUT_EN
   localparam int          MAXW     = TO - 1;
`else
   localparam int          MAXW     = 7;
`endif

   logic clk = 1'b0;
   logic rst;

   pc_fetch_if bus ();

   pc_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int          total   = 0;
   int          bad     = 0;
   bit          pc_rand = 1'b0;
   logic [29:0] m_pc;
   logic [31:0] m_ir;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge; pc_wr either randomized or left as preset by the caller.
   task automatic tick();
      if (pc_rand) begin
         bus.pc_wr = ($urandom_range(0, 2) == 0);
         bus.nPC   = 30'($urandom);
      end
      @(posedge clk);
      #1;
      if (bus.pc_wr) m_pc = bus.nPC;
      bus.pc_wr = 1'b0;
      chk("curPC", {2'b00, bus.curPC}, {2'b00, m_pc});
   endtask

   // Full fetch transaction with 'waits' ack-low REQ cycles.
   task automatic fetch(input int waits, input logic [31:0] data, input bit poke);
      logic [31:0] exp_addr;
      exp_addr         = {m_pc, 2'b00};
      bus.fetch_start  = 1'b1;
      bus.imem_ack     = 1'b0;
      tick();
      bus.fetch_start  = 1'b0;
      chk("req_up", {31'd0, bus.imem_req}, 32'd1);
      chk("addr", bus.imem_addr, exp_addr);
      chk("busy_up", {31'd0, bus.busy}, 32'd1);
      chk("irv_early", {31'd0, bus.ir_valid}, 32'd0);
      for (int w = 0; w < waits; w++) begin
         bus.fetch_start = poke;
         bus.imem_rdata  = $urandom;
         tick();
         chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
         chk("addr_hold", bus.imem_addr, exp_addr);
         chk("irv_wait", {31'd0, bus.ir_valid}, 32'd0);
         chk("ir_wait", bus.ir, m_ir);
         chk("err_wait", {31'd0, bus.fetch_err}, 32'd0);
      end
      bus.fetch_start = 1'b0;
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = data;
      tick();
      bus.imem_ack    = 1'b0;
      m_ir            = data;
      chk("irv_pulse", {31'd0, bus.ir_valid}, 32'd1);
      chk("ir_load", bus.ir, m_ir);
      chk("req_drop", {31'd0, bus.imem_req}, 32'd0);
      chk("busy_done", {31'd0, bus.busy}, 32'd1);
      chk("err_done", {31'd0, bus.fetch_err}, 32'd0);
      bus.fetch_start = poke;
      bus.imem_ack    = poke;
      tick();
      bus.fetch_start = 1'b0;
      bus.imem_ack    = 1'b0;
      chk("irv_end", {31'd0, bus.ir_valid}, 32'd0);
      chk("busy_end", {31'd0, bus.busy}, 32'd0);
      chk("req_end", {31'd0, bus.imem_req}, 32'd0);
      chk("ir_hold", bus.ir, m_ir);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_pc"}, {2'b00, bus.curPC}, {2'b00, RESET_PC});
      chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
      chk({tag, "_ir"}, bus.ir, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_irv"}, {31'd0, bus.ir_valid}, 32'd0);
      chk({tag, "_err"}, {31'd0, bus.fetch_err}, 32'd0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.pc_wr       = 1'b0;
      bus.nPC         = 30'd0;
      bus.fetch_start = 1'b0;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'd0;
      m_pc            = RESET_PC;
      m_ir            = 32'd0;
      #2;
      check_reset_state("por");
      chk("por_addr", bus.imem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Zero-wait fetch from the reset PC
      fetch(0, 32'h2408_0005, 1'b0);
      chk("t2_ir", bus.ir, 32'h2408_0005);

      // PC commit on the same edge as fetch_start
      bus.pc_wr = 1'b1;
      bus.nPC   = 30'h0C01;
      fetch(0, 32'h1234_5678, 1'b0);
      chk("t4_pc", {2'b00, bus.curPC}, 32'h0000_0C01);
      fetch(0, 32'h8C08_0000, 1'b0);
      chk("t4_addr2", bus.imem_addr, 32'h0000_3004);

      // Wait states with ignored fetch_start during REQ and DONE
      fetch(3, 32'hAABB_CCDD, 1'b1);
      tick();
      chk("t3_idle", {31'd0, bus.busy}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
      // Timeout with no ack: request stays up exactly TO cycles
      bus.fetch_start = 1'b1;
      tick();
      bus.fetch_start = 1'b0;
      for (int c = 1; c < TO; c++) begin
         chk("to_req", {31'd0, bus.imem_req}, 32'd1);
         tick();
      end
      chk("to_req_hi", {31'd0, bus.imem_req}, 32'd1);
      tick();
      chk("to_req_drop", {31'd0, bus.imem_req}, 32'd0);
      chk("to_err", {31'd0, bus.fetch_err}, 32'd1);
      chk("to_busy", {31'd0, bus.busy}, 32'd0);
      chk("to_irv", {31'd0, bus.ir_valid}, 32'd0);
      chk("to_ir", bus.ir, m_ir);
      tick();
      chk("to_err_pulse", {31'd0, bus.fetch_err}, 32'd0);
      fetch(TO - 1, 32'h0BAD_F00D, 1'b0);
`else
      // Without the timeout a long stall still completes normally
      fetch(20, 32'h0BAD_F00D, 1'b0);
`endif

      // Randomized fetches with random PC commits
      pc_rand = 1'b1;
      for (int n = 0; n < 25; n++) begin
         fetch($urandom_range(0, MAXW), $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) tick();
      end
      pc_rand = 1'b0;

      // Asynchronous reset mid-cycle from IDLE
      #3;
      rst = 1'b1;
      #1;
      check_reset_state("rst_idle");
      m_pc = RESET_PC;
      m_ir = 32'd0;
      rst  = 1'b0;
      tick();

      // Reset during REQ, then a late ack must be ignored
      fetch(1, 32'h5555_AAAA, 1'b0);
      bus.fetch_start = 1'b1;
      tick();
      bus.fetch_start = 1'b0;
      chk("r6_req", {31'd0, bus.imem_req}, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check_reset_state("r6");
      m_pc = RESET_PC;
      m_ir = 32'd0;
      rst  = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_ack = 1'b0;
      chk("r6_irv", {31'd0, bus.ir_valid}, 32'd0);
      chk("r6_ir", bus.ir, 32'd0);
      chk("r6_busy", {31'd0, bus.busy}, 32'd0);
      chk("r6_req2", {31'd0, bus.imem_req}, 32'd0);
      fetch(0, 32'h0000_000C, 1'b0);
      chk("r6_refetch", bus.imem_addr, 32'h0000_3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
